// File: rtl/key_step_pkg.sv
// key_step_pkg
//   Shared definitions for the key step counter: the per-key edge FSM state
//   encoding, the idle (released) level of an active-low key, and a helper
//   that turns a key level into a pressed flag.
package key_step_pkg;

  // Edge FSM: IDLE waits for a press, PRESS lasts one cycle and is the step,
  // HELD waits for the release.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HELD  = 2'd2
  } edge_state_t;

  // Keys are active-low, so the released level is 1.
  localparam logic KEY_RELEASED = 1'b1;

  function automatic logic key_pressed(input logic level);
    return (level != KEY_RELEASED);
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// key_edge_detect
//   Turns one asynchronous active-low key into a single-cycle step pulse.
//   The key passes through a two-flop synchroniser, then (optionally) a
//   stable-count filter, then an IDLE/PRESS/HELD edge FSM.
//
//   Build option: define KEY_STEP_COUNTER_DEBOUNCE_EN to insert the filter.
//   Without it the filtered level is the synchroniser output and
//   DEBOUNCE_CYCLES has no effect on the logic.
//
// Ports
//   clock  : clock
//   reset  : asynchronous active-high reset
//   key_n  : raw asynchronous active-low key
//   held   : filtered key-pressed level
//   step   : one-cycle pulse, high while the FSM is in PRESS
module key_edge_detect
  import key_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic held,
  output logic step
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("key_edge_detect: DEBOUNCE_CYCLES must be at least 1");
  end

  logic        sync_p0;
  logic        sync_p1;
  logic        level;
  edge_state_t state;
  edge_state_t state_next;

  // ---- stage p0/p1: two-flop synchroniser, loaded with the released level
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p0 <= KEY_RELEASED;
      sync_p1 <= KEY_RELEASED;
    end else begin
      sync_p0 <= key_n;
      sync_p1 <= sync_p0;
    end
  end

`ifdef KEY_STEP_COUNTER_DEBOUNCE_EN
  // ---- stage p2: stable-count filter
  // The filtered level only follows the synchroniser after DEBOUNCE_CYCLES
  // consecutive samples that disagree with it; any agreeing sample restarts
  // the count, so short glitches and bounces never reach the FSM.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] stable_cnt_p2;
  logic             level_p2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stable_cnt_p2 <= '0;
      level_p2      <= KEY_RELEASED;
    end else if (sync_p1 == level_p2) begin
      stable_cnt_p2 <= '0;
    end else if (stable_cnt_p2 == CNT_LAST) begin
      stable_cnt_p2 <= '0;
      level_p2      <= sync_p1;
    end else begin
      stable_cnt_p2 <= stable_cnt_p2 + 1'b1;
    end
  end

  assign level = level_p2;
`else
  assign level = sync_p1;
`endif

  // ---- edge FSM: state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---- edge FSM: next state
  // PRESS is left unconditionally, so a press yields exactly one step no
  // matter how long the key stays down.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (key_pressed(level))  state_next = PRESS;
      PRESS:                            state_next = HELD;
      HELD:    if (!key_pressed(level)) state_next = IDLE;
      default:                          state_next = IDLE;
    endcase
  end

  assign step = (state == PRESS);
  assign held = key_pressed(level);

endmodule

// File: rtl/key_step_counter.sv
// key_step_counter
//   Modulo-MODULUS up/down counter driven by two push keys. Each key goes
//   through its own key_edge_detect (synchroniser, optional filter, edge
//   FSM); each press gives one step of the counter.
//
//   Build option: define KEY_STEP_COUNTER_DEBOUNCE_EN to add the
//   DEBOUNCE_CYCLES stable-count filter to both keys.
//
// Parameters
//   WIDTH           : count width, 2 <= MODULUS <= 2**WIDTH
//   MODULUS         : count runs 0..MODULUS-1
//   DEBOUNCE_CYCLES : filter depth (only used with the filter built in)
//
// Ports
//   clock      : clock
//   reset      : asynchronous active-high reset
//   key_up_n   : active-low increment key (asynchronous)
//   key_down_n : active-low decrement key (asynchronous)
//   clear      : synchronous clear of count, wins over any step
//   count      : current count
//   wrap       : one-cycle pulse in the cycle after the count wrapped
//   up_held    : filtered up-key pressed level
//   down_held  : filtered down-key pressed level
module key_step_counter
  import key_step_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int MODULUS         = 10,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             key_up_n,
  input  logic             key_down_n,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             up_held,
  output logic             down_held
);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("key_step_counter: MODULUS must lie in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] COUNT_MAX = WIDTH'(MODULUS - 1);

  function automatic logic [WIDTH-1:0] count_inc(input logic [WIDTH-1:0] c);
    return (c == COUNT_MAX) ? '0 : c + 1'b1;
  endfunction

  function automatic logic [WIDTH-1:0] count_dec(input logic [WIDTH-1:0] c);
    return (c == '0) ? COUNT_MAX : c - 1'b1;
  endfunction

  logic             up_step;
  logic             down_step;
  logic [WIDTH-1:0] count_next;
  logic             wrap_next;

  key_edge_detect #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_up_key (
    .clock (clock),
    .reset (reset),
    .key_n (key_up_n),
    .held  (up_held),
    .step  (up_step)
  );

  key_edge_detect #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_down_key (
    .clock (clock),
    .reset (reset),
    .key_n (key_down_n),
    .held  (down_held),
    .step  (down_step)
  );

  // ---- counter stage: next count and wrap
  // Simultaneous up and down steps cancel. Clear only touches the count,
  // never the key FSMs, so a key held through clear does not step again.
  always_comb begin
    count_next = count;
    wrap_next  = 1'b0;
    if (clear) begin
      count_next = '0;
    end else if (up_step && !down_step) begin
      count_next = count_inc(count);
      wrap_next  = (count == COUNT_MAX);
    end else if (down_step && !up_step) begin
      count_next = count_dec(count);
      wrap_next  = (count == '0);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_next;
      wrap  <= wrap_next;
    end
  end

endmodule

// File: tb/tb_key_step_counter.sv
// tb_key_step_counter
//   Directed scenarios plus randomized key/clear/reset traffic against a
//   reference model built from the key rules: a key sample history, a
//   filtered level derived from it, and one step two cycles after each
//   filtered press edge. Define KEY_STEP_COUNTER_DEBOUNCE_EN for the
//   filtered build.
module tb_key_step_counter;

  localparam int WIDTH = 4;
  localparam int MOD   = 10;
  localparam int DEB   = 4;
`ifdef KEY_STEP_COUNTER_DEBOUNCE_EN
  localparam int LAT = 3 + DEB;
`else
  localparam int LAT = 3;
`endif
  localparam int MAXC = 8192;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             key_up_n = 1'b1;
  logic             key_down_n = 1'b1;
  logic             clear = 1'b0;
  logic [WIDTH-1:0] count;
  logic             wrap;
  logic             up_held;
  logic             down_held;

  key_step_counter #(
    .WIDTH           (WIDTH),
    .MODULUS         (MOD),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .key_up_n   (key_up_n),
    .key_down_n (key_down_n),
    .clear      (clear),
    .count      (count),
    .wrap       (wrap),
    .up_held    (up_held),
    .down_held  (down_held)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int wrap_seen = 0;

  // Reference model state
  bit samp [2][MAXC];
  bit filt [2][MAXC];
  int cyc;
  int m_count;
  int m_wrap;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock edge of the reference model, using the inputs in force at
  // the edge.
  task automatic model_edge();
    bit keys [2];
    bit st [2];
    bit v;
    bit stable;
    keys[0] = key_up_n;
    keys[1] = key_down_n;
    cyc++;
    if (cyc >= MAXC) begin
      $display("FAIL model_depth: got %0d expected below %0d", cyc, MAXC);
      $fatal(1, "model history exhausted");
    end
    for (int k = 0; k < 2; k++) begin
      st[k] = 1'b0;
      if (reset) begin
        samp[k][cyc] = 1'b1;
        filt[k][cyc] = 1'b1;
      end else begin
        samp[k][cyc] = keys[k];
`ifdef KEY_STEP_COUNTER_DEBOUNCE_EN
        // Level changes once the last DEB synchronised samples all agree
        // on a value different from the current level.
        v = samp[k][cyc-2];
        stable = 1'b1;
        for (int i = 2; i <= DEB + 1; i++)
          if (samp[k][cyc-i] != v) stable = 1'b0;
        filt[k][cyc] = (stable && v != filt[k][cyc-1]) ? v : filt[k][cyc-1];
`else
        v = 1'b0;
        stable = 1'b0;
        filt[k][cyc] = samp[k][cyc-1];
`endif
        st[k] = (filt[k][cyc-2] == 1'b0) && (filt[k][cyc-3] == 1'b1);
      end
    end
    if (reset || clear) begin
      m_count = 0;
      m_wrap  = 0;
    end else if (st[0] && !st[1]) begin
      m_wrap  = (m_count == MOD - 1);
      m_count = (m_count + 1) % MOD;
    end else if (st[1] && !st[0]) begin
      m_wrap  = (m_count == 0);
      m_count = (m_count + MOD - 1) % MOD;
    end else begin
      m_wrap = 0;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    check("count", int'(count), m_count);
    check("wrap", int'(wrap), m_wrap);
    check("up_held", int'(up_held), filt[0][cyc] ? 0 : 1);
    check("down_held", int'(down_held), filt[1][cyc] ? 0 : 1);
    if (wrap) wrap_seen++;
    @(negedge clock);
  endtask

  task automatic raise_reset();
    reset = 1'b1;
    #1;
    check("rst_async_count", int'(count), 0);
    check("rst_async_wrap", int'(wrap), 0);
    check("rst_async_up_held", int'(up_held), 0);
    check("rst_async_down_held", int'(down_held), 0);
  endtask

  task automatic do_reset();
    key_up_n = 1'b1;
    key_down_n = 1'b1;
    clear = 1'b0;
    raise_reset();
    repeat (3) tick();
    reset = 1'b0;
    repeat (4) tick();
  endtask

  task automatic press(input bit up, input bit dn, input int hold, input int gap);
    key_up_n = !up;
    key_down_n = !dn;
    repeat (hold) tick();
    key_up_n = 1'b1;
    key_down_n = 1'b1;
    repeat (gap) tick();
  endtask

  function automatic int pick_dur();
`ifdef KEY_STEP_COUNTER_DEBOUNCE_EN
    if ($urandom_range(0, 4) == 0) return int'($urandom_range(1, DEB - 1));
`endif
    return int'($urandom_range(3, 12));
  endfunction

  initial begin
    int first;
    int base;
    int rem [2];
    bit lvl [2];
    int rst_rem;

    for (int k = 0; k < 2; k++)
      for (int i = 0; i < MAXC; i++) begin
        samp[k][i] = 1'b1;
        filt[k][i] = 1'b1;
      end
    cyc = 16;
    m_count = 0;
    m_wrap = 0;

    // Reset state
    @(negedge clock);
    repeat (3) tick();
    check("reset_count", int'(count), 0);
    check("reset_wrap", int'(wrap), 0);
    reset = 1'b0;
    repeat (4) tick();

    // One clean up press held 20 cycles: one step at the expected latency
    first = -1;
    key_up_n = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (first < 0 && count == 4'd1) first = i;
    end
    key_up_n = 1'b1;
    repeat (12) tick();
    check("s1_latency", first, LAT + 1);
    check("s1_count", int'(count), 1);

    // Ten up presses from reset: 1..9 then 0, one wrap pulse
    do_reset();
    base = wrap_seen;
    for (int i = 1; i <= 10; i++) begin
      press(1'b1, 1'b0, 8, 12);
      check("s2_count", int'(count), i % 10);
    end
    check("s2_wraps", wrap_seen - base, 1);

    // One down press from reset: 9 with one wrap pulse
    do_reset();
    base = wrap_seen;
    press(1'b0, 1'b1, 8, 12);
    check("s3_count", int'(count), 9);
    check("s3_wraps", wrap_seen - base, 1);

`ifdef KEY_STEP_COUNTER_DEBOUNCE_EN
    // Short glitch ignored, bouncy 30-cycle hold gives one step
    do_reset();
    base = wrap_seen;
    press(1'b1, 1'b0, 3, 15);
    check("s4_glitch", int'(count), 0);
    for (int j = 0; j < 30; j++) begin
      key_up_n = (j == 6 || j == 11 || j == 12 || j == 17 || j == 22 || j == 26);
      tick();
    end
    key_up_n = 1'b1;
    repeat (15) tick();
    check("s4_bounce", int'(count), 1);
    check("s4_wraps", wrap_seen - base, 0);
`endif

    // Up and down together at count 5
    do_reset();
    repeat (5) press(1'b1, 1'b0, 8, 12);
    check("s5_pre", int'(count), 5);
    base = wrap_seen;
    press(1'b1, 1'b1, 8, 12);
    check("s5_count", int'(count), 5);
    check("s5_wraps", wrap_seen - base, 0);

    // Clear while up is held at 7, then reset mid-press
    do_reset();
    repeat (6) press(1'b1, 1'b0, 8, 12);
    key_up_n = 1'b0;
    repeat (LAT + 1) tick();
    check("s6_count7", int'(count), 7);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("s6_clear", int'(count), 0);
    repeat (10) tick();
    check("s6_held_after_clear", int'(count), 0);
    key_up_n = 1'b1;
    repeat (12) tick();
    key_up_n = 1'b0;
    repeat (LAT) tick();
    raise_reset();
    repeat (3) tick();
    check("s6_in_reset", int'(count), 0);
    key_up_n = 1'b1;
    tick();
    reset = 1'b0;
    repeat (15) tick();
    check("s6_abort", int'(count), 0);

    // Key still held as reset deasserts: one step afterwards
    key_up_n = 1'b0;
    repeat (LAT + 3) tick();
    check("s7_pre", int'(count), 1);
    raise_reset();
    repeat (3) tick();
    reset = 1'b0;
    repeat (LAT + 8) tick();
    check("s7_held_reset", int'(count), 1);
    key_up_n = 1'b1;
    repeat (12) tick();

    // Randomized keys, clear and occasional reset against the model
    lvl[0] = 1'b1;
    lvl[1] = 1'b1;
    rem[0] = 5;
    rem[1] = 9;
    rst_rem = 0;
    for (int n = 0; n < 2000; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (rem[k] == 0) begin
          lvl[k] = !lvl[k];
          rem[k] = pick_dur();
        end
        rem[k]--;
      end
      key_up_n = lvl[0];
      key_down_n = lvl[1];
      clear = ($urandom_range(0, 99) < 3);
      if (rst_rem > 0) rst_rem--;
      else if ($urandom_range(0, 399) == 0) rst_rem = 3;
      reset = (rst_rem > 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
